// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin-operated vend controller with binary credit, cancel/refund and greedy change payout
module vend_controller #(
  parameter int PRICE      = 30,
  parameter int MAX_CREDIT = 95,
  parameter int CREDIT_W   = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [2:0]          i_sensor,
  input  logic                i_cancel,
  input  logic                i_vend_ack,
  input  logic                i_change_ready,
  output logic                o_release_soda,
  output logic [2:0]          o_change_coin,
  output logic                o_coin_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_CHANGE  = 3'd3;
  localparam logic [2:0] S_REFUND  = 3'd4;

  localparam logic [2:0] COIN_Q = 3'b001;
  localparam logic [2:0] COIN_D = 3'b010;
  localparam logic [2:0] COIN_N = 3'b100;

  localparam logic [CREDIT_W:0]   L_PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   L_MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] L_PRICE   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] L_Q       = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] L_D       = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] L_N       = CREDIT_W'(5);

  logic [2:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_release;
  logic [2:0]          r_change;
  logic                r_reject;
  logic                r_busy;

  logic [2:0]          w_state;
  logic [CREDIT_W-1:0] w_credit;
  logic                w_release;
  logic [2:0]          w_change;
  logic                w_reject;
  logic                w_coin_present;
  logic                w_coin_valid;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_remain;
  logic [2:0]          w_pay_coin;
  logic [CREDIT_W-1:0] w_pay_val;
  logic [CREDIT_W-1:0] w_pay_left;

  // Sum is one bit wider than credit so the ceiling compare cannot wrap.
  always_comb begin
    w_coin_val = '0;
    case (i_sensor)
      COIN_Q:  w_coin_val = {1'b0, L_Q};
      COIN_D:  w_coin_val = {1'b0, L_D};
      COIN_N:  w_coin_val = {1'b0, L_N};
      default: w_coin_val = '0;
    endcase
  end

  assign w_coin_present = |i_sensor;
  assign w_coin_valid   = (i_sensor == COIN_Q) || (i_sensor == COIN_D) || (i_sensor == COIN_N);
  assign w_sum          = {1'b0, r_credit} + w_coin_val;
  assign w_remain       = r_credit - L_PRICE;
  assign w_pay_left     = r_credit - w_pay_val;

  always_comb begin
    w_pay_coin = COIN_N;
    w_pay_val  = L_N;
    if (r_credit >= L_Q) begin
      w_pay_coin = COIN_Q;
      w_pay_val  = L_Q;
    end else if (r_credit >= L_D) begin
      w_pay_coin = COIN_D;
      w_pay_val  = L_D;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_credit  = r_credit;
    w_release = 1'b0;
    w_change  = 3'b000;
    w_reject  = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (i_cancel && (r_state == S_COLLECT)) begin
          w_state  = S_REFUND;
          w_reject = w_coin_present;
        end else if (w_coin_present) begin
          if (!w_coin_valid || (w_sum > L_MAX_W)) begin
            w_reject = 1'b1;
          end else begin
            w_credit = w_sum[CREDIT_W-1:0];
            if (w_sum >= L_PRICE_W) begin
              w_state   = S_VEND;
              w_release = 1'b1;
            end else begin
              w_state = S_COLLECT;
            end
          end
        end
      end
      S_VEND: begin
        w_reject  = w_coin_present;
        w_release = 1'b1;
        if (i_vend_ack) begin
          w_release = 1'b0;
          w_credit  = w_remain;
          w_state   = (w_remain == '0) ? S_IDLE : S_CHANGE;
        end
      end
      S_CHANGE, S_REFUND: begin
        w_reject = w_coin_present;
        if (r_credit == '0) begin
          w_state = S_IDLE;
        end else if (i_change_ready) begin
          w_change = w_pay_coin;
          w_credit = w_pay_left;
          if (w_pay_left == '0) w_state = S_IDLE;
        end
      end
      default: begin
        w_state  = S_IDLE;
        w_credit = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_credit  <= '0;
      r_release <= 1'b0;
      r_change  <= 3'b000;
      r_reject  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_credit  <= w_credit;
      r_release <= w_release;
      r_change  <= w_change;
      r_reject  <= w_reject;
      r_busy    <= (w_state == S_VEND) || (w_state == S_CHANGE) || (w_state == S_REFUND);
    end
  end

  assign o_release_soda = r_release;
  assign o_change_coin  = r_change;
  assign o_coin_reject  = r_reject;
  assign o_credit       = r_credit;
  assign o_busy         = r_busy;

endmodule
